// File: rtl/lcd_read_fsm_pkg.sv
// -----------------------------------------------------------------------------
// lcd_read_fsm_pkg
// Shared LCD definitions for the read sequencer: 4-bit state encodings,
// default bus timing constants (in 50 MHz clock cycles) and a small helper
// used to detect the last cycle of a timed phase.
// -----------------------------------------------------------------------------
package lcd_read_fsm_pkg;

    // Read sequencer states, 4-bit encoded.
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_SETUP_HIGH  = 4'd1,
        ST_ACTIVE_HIGH = 4'd2,
        ST_HOLD_HIGH   = 4'd3,
        ST_GAP         = 4'd4,
        ST_SETUP_LOW   = 4'd5,
        ST_ACTIVE_LOW  = 4'd6,
        ST_HOLD_LOW    = 4'd7,
        ST_DONE        = 4'd8
    } lcd_rd_state_t;

    // Default timing, in clock cycles.
    localparam int LCD_T_SETUP  = 2;    // RS/RW stable before E rises
    localparam int LCD_T_E      = 12;   // E high time
    localparam int LCD_T_HOLD   = 1;    // hold after E falls
    localparam int LCD_T_GAP    = 50;   // spacing between nibbles / polls
    localparam int LCD_POLL_MAX = 255;  // maximum busy-flag reads per request

    // Width of the phase counter and the poll counter.
    localparam int LCD_CNT_W = 12;

    // True on the final cycle of a phase lasting 'len' cycles, given a
    // counter that starts at zero on phase entry.
    function automatic logic lcd_phase_last(
        input logic [LCD_CNT_W-1:0] cnt,
        input int                   len
    );
        return (cnt == LCD_CNT_W'(len - 1));
    endfunction

endpackage

// File: rtl/lcd_read_fsm.sv
// -----------------------------------------------------------------------------
// lcd_read_fsm
// Performs one 8-bit read from a 4-bit HD44780-style LCD bus as two nibble
// strobes (high nibble first). With poll=1 and rs_sel=0 it repeats the read
// until the busy flag (bit 7) clears or POLL_MAX reads have been made.
//
// Ports
//   clk      : system clock, all logic on the rising edge
//   reset    : synchronous, active-low reset
//   start    : one-cycle request, only honoured in IDLE
//   rs_sel   : RS value for the read (0 busy/address, 1 data RAM), latched
//   poll     : repeat until BF=0 (only with rs_sel=0), latched
//   sf_d_in  : data nibble driven by the LCD
//   LCD_RS   : register select
//   LCD_RW   : read/write, 1 = read
//   LCD_E    : enable strobe
//   bus_req  : high while this block owns the LCD bus
//   rd_data  : assembled byte
//   valid    : one-cycle pulse when rd_data holds the final result
//   timeout  : one-cycle pulse alongside valid when the poll limit was hit
//
// Every output is a register. Outputs only change on state transitions, so
// each transition branch drives the values that belong to the state it enters.
// -----------------------------------------------------------------------------
module lcd_read_fsm
    import lcd_read_fsm_pkg::*;
#(
    parameter int T_SETUP  = LCD_T_SETUP,
    parameter int T_E      = LCD_T_E,
    parameter int T_HOLD   = LCD_T_HOLD,
    parameter int T_GAP    = LCD_T_GAP,
    parameter int POLL_MAX = LCD_POLL_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_sel,
    input  logic       poll,
    input  logic [3:0] sf_d_in,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic       bus_req,
    output logic [7:0] rd_data,
    output logic       valid,
    output logic       timeout
);

    lcd_rd_state_t          r_state;
    logic [LCD_CNT_W-1:0]   r_cnt;
    logic [LCD_CNT_W-1:0]   r_poll_cnt;     // completed reads in this request
    logic                   r_rs;           // latched rs_sel
    logic                   r_poll;         // latched poll
    logic                   r_gap_to_high;  // GAP precedes a fresh high nibble
    logic                   r_repoll;       // DONE must loop back for another read

    logic                   r_lcd_rs;
    logic                   r_lcd_rw;
    logic                   r_lcd_e;
    logic                   r_bus_req;
    logic [7:0]             r_rd_data;
    logic                   r_valid;
    logic                   r_timeout;

    logic                   w_busy;
    logic [LCD_CNT_W-1:0]   w_reads;
    logic                   w_limit;
    logic                   w_repoll;

    // Poll decision, evaluated while the just-finished read is in HOLD_LOW.
    // The high nibble (and so BF) is already in r_rd_data by then.
    assign w_busy   = r_poll & ~r_rs & r_rd_data[7];
    assign w_reads  = r_poll_cnt + LCD_CNT_W'(1);
    assign w_limit  = (w_reads >= LCD_CNT_W'(POLL_MAX));
    assign w_repoll = w_busy & ~w_limit;

    // Read sequencer: state, phase counter, captured data and all outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_poll_cnt    <= '0;
            r_rs          <= 1'b0;
            r_poll        <= 1'b0;
            r_gap_to_high <= 1'b0;
            r_repoll      <= 1'b0;
            r_lcd_rs      <= 1'b0;
            r_lcd_rw      <= 1'b0;
            r_lcd_e       <= 1'b0;
            r_bus_req     <= 1'b0;
            r_rd_data     <= 8'h00;
            r_valid       <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            // Pulses default low; the counter runs unless a transition clears it.
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= r_cnt + LCD_CNT_W'(1);

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state    <= ST_SETUP_HIGH;
                        r_rs       <= rs_sel;
                        r_poll     <= poll;
                        r_poll_cnt <= '0;
                        r_lcd_rs   <= rs_sel;
                        r_lcd_rw   <= 1'b1;
                        r_bus_req  <= 1'b1;
                    end
                end

                ST_SETUP_HIGH: begin
                    if (lcd_phase_last(r_cnt, T_SETUP)) begin
                        r_state <= ST_ACTIVE_HIGH;
                        r_cnt   <= '0;
                        r_lcd_e <= 1'b1;
                    end
                end

                ST_ACTIVE_HIGH: begin
                    // Sample on the last E-high cycle, when LCD data is settled.
                    if (lcd_phase_last(r_cnt, T_E)) begin
                        r_state        <= ST_HOLD_HIGH;
                        r_cnt          <= '0;
                        r_lcd_e        <= 1'b0;
                        r_rd_data[7:4] <= sf_d_in;
                    end
                end

                ST_HOLD_HIGH: begin
                    if (lcd_phase_last(r_cnt, T_HOLD)) begin
                        r_state       <= ST_GAP;
                        r_cnt         <= '0;
                        r_gap_to_high <= 1'b0;
                    end
                end

                ST_GAP: begin
                    // The same gap separates nibbles and successive poll reads.
                    if (lcd_phase_last(r_cnt, T_GAP)) begin
                        r_cnt <= '0;
                        if (r_gap_to_high) begin
                            r_state <= ST_SETUP_HIGH;
                        end else begin
                            r_state <= ST_SETUP_LOW;
                        end
                    end
                end

                ST_SETUP_LOW: begin
                    if (lcd_phase_last(r_cnt, T_SETUP)) begin
                        r_state <= ST_ACTIVE_LOW;
                        r_cnt   <= '0;
                        r_lcd_e <= 1'b1;
                    end
                end

                ST_ACTIVE_LOW: begin
                    if (lcd_phase_last(r_cnt, T_E)) begin
                        r_state        <= ST_HOLD_LOW;
                        r_cnt          <= '0;
                        r_lcd_e        <= 1'b0;
                        r_rd_data[3:0] <= sf_d_in;
                    end
                end

                ST_HOLD_LOW: begin
                    // Decide here so valid/timeout are registered for DONE.
                    if (lcd_phase_last(r_cnt, T_HOLD)) begin
                        r_state    <= ST_DONE;
                        r_cnt      <= '0;
                        r_poll_cnt <= w_reads;
                        r_repoll   <= w_repoll;
                        r_valid    <= ~w_repoll;
                        r_timeout  <= w_busy & w_limit;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here.
                    r_cnt <= '0;
                    if (r_repoll) begin
                        r_state       <= ST_GAP;
                        r_gap_to_high <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_lcd_rs  <= 1'b0;
                        r_lcd_rw  <= 1'b0;
                        r_bus_req <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_lcd_rs  <= 1'b0;
                    r_lcd_rw  <= 1'b0;
                    r_lcd_e   <= 1'b0;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign LCD_RS  = r_lcd_rs;
    assign LCD_RW  = r_lcd_rw;
    assign LCD_E   = r_lcd_e;
    assign bus_req = r_bus_req;
    assign rd_data = r_rd_data;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// -----------------------------------------------------------------------------
// tb_lcd_read_fsm
// Self-checking bench for lcd_read_fsm. The reference is a timeline model:
// a request starting its first SETUP at cycle t0 consists of N reads spaced
// PERIOD cycles apart, each with E windows and capture points at fixed offsets
// derived from the timing parameters. Expected outputs for every cycle are
// computed from that arithmetic; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_lcd_read_fsm;

    localparam int TS   = 2;
    localparam int TE   = 12;
    localparam int TH   = 1;
    localparam int TG   = 50;
    localparam int PMAX = 255;

    // Offsets inside one read, counted from its first SETUP cycle.
    localparam int LO_OFS   = TS + TE + TH + TG;          // first SETUP_LOW cycle
    localparam int DONE_OFS = 2 * (TS + TE + TH) + TG;    // DONE cycle (80)
    localparam int PERIOD   = DONE_OFS + 1 + TG;          // read-to-read spacing

    logic       clk;
    logic       reset;
    logic       start;
    logic       rs_sel;
    logic       poll;
    logic [3:0] sf_d_in;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic       bus_req;
    logic [7:0] rd_data;
    logic       valid;
    logic       timeout;

    lcd_read_fsm #(
        .T_SETUP  (TS),
        .T_E      (TE),
        .T_HOLD   (TH),
        .T_GAP    (TG),
        .POLL_MAX (PMAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rs_sel  (rs_sel),
        .poll    (poll),
        .sf_d_in (sf_d_in),
        .LCD_RS  (LCD_RS),
        .LCD_RW  (LCD_RW),
        .LCD_E   (LCD_E),
        .bus_req (bus_req),
        .rd_data (rd_data),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state.
    logic       cmp_en   = 1'b0;
    logic       m_active = 1'b0;
    logic       m_rs     = 1'b0;
    logic       m_to     = 1'b0;
    int         m_t0     = 0;
    int         m_tend   = 0;
    logic [7:0] m_rd;
    logic [7:0] rd_bytes [0:PMAX-1];

    // Monitor records.
    int   e_rise[$];
    int   e_fall[$];
    int   rw_rise[$];
    int   v_cyc[$];
    int   t_cyc[$];
    logic prev_e  = 1'b0;
    logic prev_rw = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        e_rise.delete();
        e_fall.delete();
        rw_rise.delete();
        v_cyc.delete();
        t_cyc.delete();
    endtask

    // Nibble the LCD presents in cycle c: the correct nibble inside each E
    // window, its complement elsewhere so a mistimed capture is visible.
    function automatic logic [3:0] stim_nib(input int c);
        int r;
        int k;
        int rr;
        logic [7:0] b;
        if (!m_active || c < m_t0 || c > m_tend) return 4'h0;
        r  = c - m_t0;
        k  = r / PERIOD;
        rr = r % PERIOD;
        b  = rd_bytes[k];
        if (rr >= TS && rr < TS + TE) return b[7:4];
        if (rr >= LO_OFS + TS && rr < LO_OFS + TS + TE) return b[3:0];
        if (rr < LO_OFS) return ~b[7:4];
        return ~b[3:0];
    endfunction

    // Issue an accepted request in the current cycle and register it with the model.
    task automatic launch(input logic rs, input logic pl);
        int n;
        logic busy;
        n = 0;
        for (int k = 0; k < PMAX; k++) begin
            n    = k + 1;
            busy = pl && !rs && rd_bytes[k][7];
            m_to = busy && (n == PMAX);
            if (!busy) break;
        end
        m_t0     = cyc + 1;
        m_tend   = m_t0 + (n - 1) * PERIOD + DONE_OFS;
        m_rs     = rs;
        m_active = 1'b1;
        start    = 1'b1;
        rs_sel   = rs;
        poll     = pl;
        tick(1);
        start  = 1'b0;
        rs_sel = ~rs;
        poll   = ~pl;
    endtask

    // Per-cycle comparison of every output against the timeline model.
    task automatic check_cycle();
        int r;
        int k;
        int rr;
        logic act;
        logic e_x;
        logic v_x;
        logic t_x;
        act = m_active && (cyc >= m_t0) && (cyc <= m_tend);
        r = 0;
        k = 0;
        rr = 0;
        if (act) begin
            r  = cyc - m_t0;
            k  = r / PERIOD;
            rr = r % PERIOD;
        end
        e_x = act && ((rr >= TS && rr < TS + TE) ||
                      (rr >= LO_OFS + TS && rr < LO_OFS + TS + TE));
        v_x = act && (cyc == m_tend);
        t_x = v_x && m_to;
        chk("lcd_rs",  32'(LCD_RS),  32'(act && m_rs));
        chk("lcd_rw",  32'(LCD_RW),  32'(act));
        chk("lcd_e",   32'(LCD_E),   32'(e_x));
        chk("bus_req", 32'(bus_req), 32'(act));
        chk("valid",   32'(valid),   32'(v_x));
        chk("timeout", 32'(timeout), 32'(t_x));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        // Captures on the last E cycle become visible one cycle later.
        if (act && rr == TS + TE - 1)          m_rd[7:4] <= rd_bytes[k][7:4];
        if (act && rr == LO_OFS + TS + TE - 1) m_rd[3:0] <= rd_bytes[k][3:0];
    endtask

    always @(negedge clk) begin
        if (cmp_en) check_cycle();
    end

    // Edge and pulse recorder for the literal checks.
    always @(negedge clk) begin
        if (LCD_E === 1'b1 && prev_e !== 1'b1) e_rise.push_back(cyc);
        if (LCD_E !== 1'b1 && prev_e === 1'b1) e_fall.push_back(cyc);
        if (LCD_RW === 1'b1 && prev_rw !== 1'b1) rw_rise.push_back(cyc);
        if (valid === 1'b1) v_cyc.push_back(cyc);
        if (timeout === 1'b1) t_cyc.push_back(cyc);
        prev_e  <= LCD_E;
        prev_rw <= LCD_RW;
    end

    initial begin
        sf_d_in = 4'h0;
        forever begin
            @(posedge clk);
            #2;
            sf_d_in = stim_nib(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        reset  = 1'b0;
        start  = 1'b0;
        rs_sel = 1'b0;
        poll   = 1'b0;
        m_rd  <= 8'h00;
        for (int k = 0; k < PMAX; k++) rd_bytes[k] = 8'h00;
        tick(3);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        cmp_en = 1'b1;
        reset  = 1'b1;
        tick(2);

        // Data read with poll set: rs_sel=1 means a single read even though BF=1.
        rd_bytes[0] = 8'hA5;
        clear_mon();
        c0 = cyc;
        launch(1'b1, 1'b1);
        tick(90);
        chk("dr_e_rises", e_rise.size(), 2);
        chk("dr_e_rise0", (e_rise.size() > 0) ? e_rise[0] : -1, c0 + 3);
        chk("dr_e_fall0", (e_fall.size() > 0) ? e_fall[0] : -1, c0 + 15);
        chk("dr_e_rise1", (e_rise.size() > 1) ? e_rise[1] : -1, c0 + 68);
        chk("dr_e_fall1", (e_fall.size() > 1) ? e_fall[1] : -1, c0 + 80);
        chk("dr_rw_rise", (rw_rise.size() > 0) ? rw_rise[0] : -1, c0 + 1);
        chk("dr_valids",  v_cyc.size(), 1);
        chk("dr_valid_at", (v_cyc.size() > 0) ? v_cyc[0] : -1, c0 + 81);
        chk("dr_rd_data", 32'(rd_data), 32'hA5);
        chk("dr_timeouts", t_cyc.size(), 0);

        // Start handling: stray starts mid-transaction and in DONE are ignored,
        // a start in the following cycle is accepted.
        rd_bytes[0] = 8'h4B;
        clear_mon();
        c0 = cyc;
        launch(1'b1, 1'b0);
        tick(4);
        start = 1'b1; rs_sel = 1'b0;
        tick(1);
        start = 1'b0;
        tick(34);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(40);
        start = 1'b1;
        tick(1);
        rd_bytes[0] = 8'h69;
        launch(1'b0, 1'b0);
        tick(90);
        chk("sh_valids", v_cyc.size(), 2);
        chk("sh_valid0", (v_cyc.size() > 0) ? v_cyc[0] : -1, c0 + 81);
        chk("sh_valid1", (v_cyc.size() > 1) ? v_cyc[1] : -1, c0 + 163);
        chk("sh_e_rises", e_rise.size(), 4);
        chk("sh_rd_data", 32'(rd_data), 32'h69);

        // Busy poll: three BF=1 reads, then 8'h17.
        rd_bytes[0] = 8'hB2;
        rd_bytes[1] = 8'h9C;
        rd_bytes[2] = 8'hFF;
        rd_bytes[3] = 8'h17;
        clear_mon();
        c0 = cyc;
        launch(1'b0, 1'b1);
        tick(480);
        chk("bp_e_rises", e_rise.size(), 8);
        chk("bp_read2_e", (e_rise.size() > 2) ? e_rise[2] : -1, c0 + 134);
        chk("bp_valids", v_cyc.size(), 1);
        chk("bp_valid_at", (v_cyc.size() > 0) ? v_cyc[0] : -1, c0 + 474);
        chk("bp_timeouts", t_cyc.size(), 0);
        chk("bp_rd_data", 32'(rd_data), 32'h17);

        // Reset while E is high aborts with no valid; a new read then works.
        rd_bytes[0] = 8'hD2;
        clear_mon();
        c0 = cyc;
        launch(1'b1, 1'b0);
        tick(9);
        chk("rm_e_before", 32'(LCD_E), 32'h1);
        reset = 1'b0;
        tick(1);
        reset    = 1'b1;
        m_active = 1'b0;
        m_rd    <= 8'h00;
        chk("rm_e_after",   32'(LCD_E),   32'h0);
        chk("rm_bus_after", 32'(bus_req), 32'h0);
        chk("rm_rd_after",  32'(rd_data), 32'h00);
        tick(100);
        chk("rm_no_valid", v_cyc.size(), 0);
        rd_bytes[0] = 8'h3C;
        clear_mon();
        c0 = cyc;
        launch(1'b1, 1'b0);
        tick(90);
        chk("rm_valid_at", (v_cyc.size() > 0) ? v_cyc[0] : -1, c0 + 81);
        chk("rm_rd_data", 32'(rd_data), 32'h3C);

        // Poll timeout: BF stuck at 1.
        for (int k = 0; k < PMAX; k++) rd_bytes[k] = 8'h80 | 8'(k & 127);
        clear_mon();
        c0 = cyc;
        launch(1'b0, 1'b1);
        tick(33360);
        chk("to_e_rises", e_rise.size(), 2 * PMAX);
        chk("to_valids", v_cyc.size(), 1);
        chk("to_valid_at", (v_cyc.size() > 0) ? v_cyc[0] : -1, c0 + 33355);
        chk("to_timeouts", t_cyc.size(), 1);
        chk("to_timeout_at", (t_cyc.size() > 0) ? t_cyc[0] : -1, c0 + 33355);
        chk("to_rd_data", 32'(rd_data), 32'hFE);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
